// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, FSM state type, default reset PC.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned RESET_PC_DEFAULT = 0;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: write enable, flush-to-NOP, and a valid bit (bubble = NOP with valid=0).
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write_en,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  // Flush wins over a held register; a write without a load inserts a bubble and keeps pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (write_en) begin
      if (load) begin
        pc    <= pc_in;
        instr <= instr_in;
        valid <= 1'b1;
      end else begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, REQ/WAIT/HOLD/DROP fetch FSM, stall hold buffer, IF/ID register.
// Optional FETCH_PERF_EN adds fetch/stall/flush performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCWrite,
  input  logic            IFID_Write,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [XLEN-1:0] IFID_pc,
  output logic [31:0]     IFID_instr,
  output logic            IFID_valid,
  output fetch_state_e    dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flushes
`endif
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] req_pc, req_pc_next;
  logic [31:0]     hold_data, hold_data_next;
  logic [31:0]     deliver_instr;
  logic [XLEN-1:0] target;
  logic            stall;
  logic            deliver;

  assign stall     = !PCWrite || !IFID_Write;
  assign target    = {branch_target[XLEN-1:2], 2'b00};
  assign dbg_state = state;

  // Request handshake: a request transfers on a rising edge where imem_req_valid && imem_req_ready;
  // valid never depends on ready, and at most one request is outstanding.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    req_pc_next    = req_pc;
    hold_data_next = hold_data;
    deliver        = 1'b0;
    deliver_instr  = imem_rsp_data;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc;
    case (state)
      REQ: begin
        imem_req_valid = 1'b1;
        if (flush) begin
          // An old-address request accepted now must have its response dropped.
          state_next = imem_req_ready ? DROP : REQ;
        end else if (imem_req_ready) begin
          req_pc_next = pc;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_next = imem_rsp_valid ? REQ : DROP;
        end else if (imem_rsp_valid) begin
          if (stall) begin
            hold_data_next = imem_rsp_data;
            state_next     = HOLD;
          end else begin
            deliver    = 1'b1;
            state_next = REQ;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          hold_data_next = '0;
          state_next     = REQ;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_data;
          state_next    = REQ;
        end
      end
      DROP: begin
        if (imem_rsp_valid) state_next = REQ;
      end
      default: state_next = REQ;
    endcase
    if (flush) pc_next = target;
    else if (deliver) pc_next = pc + XLEN'(4);
    if (reset) imem_req_valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= REQ;
      pc        <= RESET_PC;
      req_pc    <= RESET_PC;
      hold_data <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      req_pc    <= req_pc_next;
      hold_data <= hold_data_next;
    end
  end

  ifid_reg #(.XLEN(XLEN)) u_ifid (
    .clk      (clk),
    .reset    (reset),
    .write_en (IFID_Write),
    .flush    (flush),
    .load     (deliver),
    .pc_in    (req_pc),
    .instr_in (deliver_instr),
    .pc       (IFID_pc),
    .instr    (IFID_instr),
    .valid    (IFID_valid)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if (deliver) perf_fetched <= perf_fetched + 32'd1;
      if (stall && !flush) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule
